data_mem_arbiter: RTL and testbench

- Shares the single data_memory port between two requesters: m0 (CPU data side of mips_cpu_harvard) and m1 (auxiliary loader/debug master).
- Sits between the masters and data_memory.
- Arbitrates requests, forwards one transaction at a time, and applies a wait-timeout so a stalled memory cannot hang the CPU.

---
 rtl/dmarb_pkg.sv | 15 +
 rtl/dmarb_wait_timer.sv | 30 +++
 rtl/data_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmarb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmarb_pkg;

    typedef logic [1:0] dmarb_state_t;

    localparam dmarb_state_t IDLE  = 2'd0;
    localparam dmarb_state_t BUSY0 = 2'd1;
    localparam dmarb_state_t BUSY1 = 2'd2;

    localparam int unsigned M0 = 0;
    localparam int unsigned M1 = 1;

    localparam logic [31:0] TIMEOUT_READDATA = 32'hDEADBEEF;

endpackage

// File: rtl/dmarb_wait_timer.sv
// Counts consecutive stalled cycles of the current grant and flags expiry on the
// cycle that would bring the count to LIMIT.
module dmarb_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_enable,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [7:0] count_q;

    assign expired = clk_enable & inc & (count_q == 8'(LIMIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clk_enable) begin
            if (clear) begin
                count_q <= '0;
            end else if (inc) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the shared data_memory port with a wait timeout.
// Build option DMARB_ROUND_ROBIN_EN: alternating priority instead of fixed m0 priority.
module data_mem_arbiter
    import dmarb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_CONSEC     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_enable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_waitrequest,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_waitrequest,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    input  logic [DATA_W-1:0]   mem_readdata,
    input  logic                mem_waitrequest,
    output logic [1:0]          grant,
    output logic                timeout_error
);

    dmarb_state_t state_q, state_d;
    logic         m0_req, m1_req, any_req;
    logic         busy0, busy1, busy;
    logic         cur_read, cur_write, cur_req;
    logic         complete, vacant, abort, done, rearb, pick_m1;
    logic         timer_inc, timer_clear;
    logic         timeout_error_q;
    logic [DATA_W-1:0] resp_data;

    assign m0_req  = m0_read | m0_write;
    assign m1_req  = m1_read | m1_write;
    assign any_req = m0_req | m1_req;

    assign busy0 = (state_q == BUSY0);
    assign busy1 = (state_q == BUSY1);
    assign busy  = busy0 | busy1;

    assign cur_read  = busy1 ? m1_read  : (busy0 & m0_read);
    assign cur_write = busy1 ? m1_write : (busy0 & m0_write);
    assign cur_req   = cur_read | cur_write;

    assign complete = clk_enable & cur_req & ~mem_waitrequest;
    // Owner dropped its request after being re-granted: release without a transfer.
    assign vacant   = clk_enable & busy & ~cur_req;
    assign done     = complete | abort;
    assign rearb    = clk_enable & (~busy | done | vacant);

    assign timer_inc   = cur_req & mem_waitrequest;
    assign timer_clear = ~timer_inc | abort;

    dmarb_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clk_enable(clk_enable),
        .clear     (timer_clear),
        .inc       (timer_inc),
        .expired   (abort)
    );

`ifdef DMARB_ROUND_ROBIN_EN
    logic prio_q, favour_m1;

    // The master that just finished drops to lowest priority.
    assign favour_m1 = done ? busy0 : prio_q;
    assign pick_m1   = m1_req & (~m0_req | favour_m1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= 1'b0;
        end else if (clk_enable) begin
            prio_q <= favour_m1;
        end
    end
`else
    localparam int unsigned CNT_W = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);

    logic [CNT_W-1:0] consec_q, consec_d;

    assign pick_m1 = m1_req & (~m0_req | (consec_q >= CNT_W'(MAX_CONSEC)));

    always_comb begin
        consec_d = consec_q;
        if (!m1_req) begin
            consec_d = '0;
        end else if (rearb && any_req) begin
            consec_d = pick_m1 ? '0 : consec_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            consec_q <= '0;
        end else if (clk_enable) begin
            consec_q <= consec_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        if (rearb) begin
            if (!any_req) begin
                state_d = IDLE;
            end else begin
                state_d = pick_m1 ? BUSY1 : BUSY0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            timeout_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (abort) begin
                timeout_error_q <= 1'b1;
            end
        end
    end

    assign mem_read       = clk_enable & ~abort & cur_read & ~cur_write;
    assign mem_write      = clk_enable & ~abort & cur_write;
    assign mem_address    = busy1 ? m1_address    : m0_address;
    assign mem_writedata  = busy1 ? m1_writedata  : m0_writedata;
    assign mem_byteenable = busy1 ? m1_byteenable : m0_byteenable;

    assign grant         = {busy1, busy0};
    assign timeout_error = timeout_error_q;

    assign resp_data = abort ? DATA_W'(TIMEOUT_READDATA) : mem_readdata;

    always_comb begin
        m0_readdata = '0;
        m1_readdata = '0;
        if (busy0) m0_readdata = resp_data;
        if (busy1) m1_readdata = resp_data;
    end

    assign m0_waitrequest = m0_req & ~(busy0 & done);
    assign m1_waitrequest = m1_req & ~(busy1 & done);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter; expected transfers go through a scoreboard queue.
module tb_data_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic reset, clk_enable;
    logic m0_read, m0_write, m1_read, m1_write;
    logic [ADDR_W-1:0] m0_address, m1_address, mem_address;
    logic [DATA_W-1:0] m0_writedata, m1_writedata, mem_writedata;
    logic [3:0] m0_byteenable, m1_byteenable, mem_byteenable;
    logic [DATA_W-1:0] m0_readdata, m1_readdata, mem_readdata;
    logic m0_waitrequest, m1_waitrequest, mem_read, mem_write, mem_waitrequest;
    logic [1:0] grant;
    logic timeout_error;

    typedef struct packed {
        logic [1:0]  grant;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    data_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16), .MAX_CONSEC(4)
    ) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
        .grant(grant), .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0;
        m0_read = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL reset_timeout_error: got %b want 0", timeout_error); end
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_m0_wait: got %b want 1", m0_waitrequest); end
        checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_m1_wait: got %b want 0", m1_waitrequest); end
        @(posedge clk); #1;
        reset = 1'b1;
        m0_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [1:0] dm;
        repeat (3) @(posedge clk); #1;
`ifdef DMARB_ROUND_ROBIN_EN
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) sb.push_back('{2'b01, 32'h1000 + 32'(4 * (i / 2)), 32'h5EED_0001});
            else            sb.push_back('{2'b10, 32'h2000 + 32'(4 * (i / 2)), 32'h5EED_0001});
        end
`else
        for (int i = 0; i < 4; i++) sb.push_back('{2'b01, 32'h1000 + 32'(4 * i), 32'h5EED_0001});
        sb.push_back('{2'b10, 32'h2000, 32'h5EED_0001});
`endif
        m0_read = 1'b1; m0_address = 32'h1000;
        m1_read = 1'b1; m1_address = 32'h2000;
        mem_readdata = 32'h5EED_0001; mem_waitrequest = 1'b0;
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            @(negedge clk);
            dm = 2'b00;
            if (mem_read === 1'b1 && mem_waitrequest === 1'b0) begin
                e = sb.pop_front();
                dm = grant;
                checks++; if (grant !== e.grant) begin errors++; $display("FAIL b2b_grant: got %b want %b", grant, e.grant); end
                checks++; if (mem_address !== e.addr) begin errors++; $display("FAIL b2b_addr: got %h want %h", mem_address, e.addr); end
                checks++; if ((grant[0] ? m0_readdata : m1_readdata) !== e.data) begin
                    errors++; $display("FAIL b2b_rdata: got %h want %h", grant[0] ? m0_readdata : m1_readdata, e.data);
                end
            end
            @(posedge clk); #1;
            if (dm[0]) m0_address = m0_address + 32'd4;
`ifdef DMARB_ROUND_ROBIN_EN
            if (dm[1]) m1_address = m1_address + 32'd4;
`else
            if (dm[1]) m1_read = 1'b0;
`endif
        end
        m0_read = 1'b0; m1_read = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d left want 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_both_write();
        exp_t e;
        logic [1:0] dm;
        bit gap = 1'b0;
        int done_n = 0;
        repeat (3) @(posedge clk); #1;
        m0_write = 1'b1; m0_address = 32'h100; m0_writedata = 32'hA0A0_0001; m0_byteenable = 4'hF;
        m1_write = 1'b1; m1_address = 32'h200; m1_writedata = 32'hB0B0_0002; m1_byteenable = 4'h3;
        mem_waitrequest = 1'b0;
        sb.push_back('{2'b01, 32'h100, 32'hA0A0_0001});
        sb.push_back('{2'b10, 32'h200, 32'hB0B0_0002});
        for (int c = 0; c < 12 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (done_n > 0 && grant === 2'b00) gap = 1'b1;
            dm = 2'b00;
            if (mem_write === 1'b1 && mem_waitrequest === 1'b0) begin
                e = sb.pop_front();
                dm = grant;
                done_n++;
                checks++; if (grant !== e.grant) begin errors++; $display("FAIL wr_grant: got %b want %b", grant, e.grant); end
                checks++; if (mem_address !== e.addr) begin errors++; $display("FAIL wr_addr: got %h want %h", mem_address, e.addr); end
                checks++; if (mem_writedata !== e.data) begin errors++; $display("FAIL wr_data: got %h want %h", mem_writedata, e.data); end
                checks++; if (mem_byteenable !== (e.grant[0] ? 4'hF : 4'h3)) begin
                    errors++; $display("FAIL wr_be: got %h want %h", mem_byteenable, e.grant[0] ? 4'hF : 4'h3);
                end
                checks++; if ((e.grant[0] ? m0_waitrequest : m1_waitrequest) !== 1'b0) begin
                    errors++; $display("FAIL wr_wait: got 1 want 0 for grant %b", e.grant);
                end
            end
            @(posedge clk); #1;
            if (dm[0]) m0_write = 1'b0;
            if (dm[1]) m1_write = 1'b0;
        end
        m0_write = 1'b0; m1_write = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL wr_pending: got %0d left want 0", sb.size()); end
        checks++; if (gap !== 1'b0) begin errors++; $display("FAIL wr_idle_gap: got %b want 0", gap); end
        sb.delete();
    endtask

    task automatic test_single_read();
        exp_t e;
        int lat = -1;
        repeat (3) @(posedge clk); #1;
        m0_read = 1'b1; m0_address = 32'h10;
        mem_readdata = 32'h0050_0000; mem_waitrequest = 1'b0;
        sb.push_back('{2'b01, 32'h10, 32'h0050_0000});
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_arb_grant: got %b want 00", grant); end
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rd_arb_wait: got %b want 1", m0_waitrequest); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rd_arb_strobe: got %b want 0", mem_read); end
        for (int c = 1; c <= 5 && lat < 0; c++) begin
            @(negedge clk);
            if (m0_waitrequest === 1'b0) begin
                lat = c;
                e = sb.pop_front();
                checks++; if (grant !== e.grant) begin errors++; $display("FAIL rd_grant: got %b want %b", grant, e.grant); end
                checks++; if (mem_address !== e.addr) begin errors++; $display("FAIL rd_addr: got %h want %h", mem_address, e.addr); end
                checks++; if (m0_readdata !== e.data) begin errors++; $display("FAIL rd_data: got %h want %h", m0_readdata, e.data); end
                checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rd_strobe: got %b want 1", mem_read); end
            end
        end
        checks++; if (lat != 1) begin errors++; $display("FAIL rd_latency: got %0d want 1", lat); end
        sb.delete();
        @(posedge clk); #1;
        m0_read = 1'b0;
    endtask

    task automatic test_wait_states();
        repeat (3) @(posedge clk); #1;
        m1_read = 1'b1; m1_address = 32'h300;
        mem_readdata = 32'h1234_5678; mem_waitrequest = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (grant !== 2'b10) begin errors++; $display("FAIL ws_grant: got %b want 10", grant); end
            checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL ws_strobe: got %b want 1", mem_read); end
            checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL ws_wait: got %b want 1", m1_waitrequest); end
        end
        @(posedge clk); #1;
        mem_waitrequest = 1'b0;
        @(negedge clk);
        checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL ws_done: got %b want 0", m1_waitrequest); end
        checks++; if (m1_readdata !== 32'h1234_5678) begin errors++; $display("FAIL ws_data: got %h want 12345678", m1_readdata); end
        checks++; if (m0_readdata !== 32'h0) begin errors++; $display("FAIL ws_other_data: got %h want 0", m0_readdata); end
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL ws_no_timeout: got %b want 0", timeout_error); end
        @(posedge clk); #1;
        m1_read = 1'b0;
    endtask

    task automatic test_timeout();
        int busy_cycles = 0;
        int abort_at = -1;
        repeat (3) @(posedge clk); #1;
        m0_read = 1'b1; m0_address = 32'h40; mem_waitrequest = 1'b1; mem_readdata = 32'h0;
        for (int c = 0; c < 40 && abort_at < 0; c++) begin
            @(negedge clk);
            if (grant === 2'b01) busy_cycles++;
            if (m0_waitrequest === 1'b0) begin
                abort_at = busy_cycles;
                checks++; if (m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL to_data: got %h want deadbeef", m0_readdata); end
                checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL to_strobe: got %b want 0", mem_read); end
            end
        end
        checks++; if (abort_at != 16) begin errors++; $display("FAIL to_cycles: got %0d want 16", abort_at); end
        @(posedge clk); #1;
        m0_read = 1'b0; mem_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout_error); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_idle: got %b want 00", grant); end
    endtask

    task automatic test_clk_enable();
        repeat (3) @(posedge clk); #1;
        m0_write = 1'b1; m0_address = 32'h80; m0_writedata = 32'hCAFE_F00D; m0_byteenable = 4'hF;
        mem_waitrequest = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        clk_enable = 1'b0; mem_waitrequest = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ce_grant: got %b want 01", grant); end
            checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL ce_strobe: got %b want 0", mem_write); end
            checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL ce_wait: got %b want 1", m0_waitrequest); end
        end
        @(posedge clk); #1;
        clk_enable = 1'b1;
        @(negedge clk);
        checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL ce_done: got %b want 0", m0_waitrequest); end
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL ce_resume: got %b want 1", mem_write); end
        checks++; if (mem_writedata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ce_data: got %h want cafef00d", mem_writedata); end
        @(posedge clk); #1;
        m0_write = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        repeat (3) @(posedge clk); #1;
        m1_write = 1'b1; m1_address = 32'h90; m1_writedata = 32'h0000_0090; mem_waitrequest = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rst_pre_grant: got %b want 10", grant); end
        #2 reset = 1'b0;
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b want 0", mem_write); end
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", timeout_error); end
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait: got %b want 1", m1_waitrequest); end
        @(posedge clk); #1;
        m1_write = 1'b0; mem_waitrequest = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_after: got %b want 00", grant); end
    endtask

    initial begin
        reset = 1'b0; clk_enable = 1'b1;
        m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_byteenable = 4'hF;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_byteenable = 4'hF;
        mem_readdata = '0; mem_waitrequest = 1'b0;
        test_reset();
        test_back_to_back();
        test_both_write();
        test_single_read();
        test_wait_states();
        test_timeout();
        test_clk_enable();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
